// File: rtl/hazard_unit_pkg.sv
// Shared pipeline-control types: hazard FSM states, per-register stall/flush
// pairs and the bundle of controls the hazard unit drives each cycle.
package hazard_unit_pkg;

   localparam int FLUSH_CTR_W = 3;

   typedef enum logic [1:0] {
      HZ_RUN         = 2'd0,
      HZ_FLUSH       = 2'd1,
      HZ_FREEZE_PEND = 2'd2
   } hz_state_t;

   typedef struct packed {
      logic stall;
      logic flush;
   } stage_ctrl_t;

   // EX/MEM and MEM/WB are never bubbled, so they carry only a hold bit.
   typedef struct packed {
      logic        pc_stall;
      stage_ctrl_t if_id;
      stage_ctrl_t id_ex;
      logic        ex_mem_stall;
      logic        mem_wb_stall;
      logic        redirect_take;
   } pipe_ctrl_t;

   function automatic pipe_ctrl_t ctrl_idle();
      pipe_ctrl_t c;
      c = '0;
      return c;
   endfunction

   function automatic pipe_ctrl_t ctrl_freeze();
      pipe_ctrl_t c;
      c              = '0;
      c.pc_stall     = 1'b1;
      c.if_id.stall  = 1'b1;
      c.id_ex.stall  = 1'b1;
      c.ex_mem_stall = 1'b1;
      c.mem_wb_stall = 1'b1;
      return c;
   endfunction

   function automatic pipe_ctrl_t ctrl_redirect();
      pipe_ctrl_t c;
      c               = '0;
      c.redirect_take = 1'b1;
      c.if_id.flush   = 1'b1;
      c.id_ex.flush   = 1'b1;
      return c;
   endfunction

   function automatic pipe_ctrl_t ctrl_load_use();
      pipe_ctrl_t c;
      c             = '0;
      c.pc_stall    = 1'b1;
      c.if_id.stall = 1'b1;
      c.id_ex.flush = 1'b1;
      return c;
   endfunction

   function automatic pipe_ctrl_t ctrl_imem_miss();
      pipe_ctrl_t c;
      c             = '0;
      c.pc_stall    = 1'b1;
      c.if_id.flush = 1'b1;
      return c;
   endfunction

endpackage

// File: rtl/hazard_unit_perf_counter.sv
// Free-running event counter: counts cycles with en_i high, wraps modulo
// 2^CNT_W, cleared by asynchronous active-high reset.
module perf_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             en_i,
   output logic [CNT_W-1:0] cnt_o
);

   logic [CNT_W-1:0] cnt_d;
   logic [CNT_W-1:0] cnt_q;

   always_comb begin
      // NOTE: default first so every path assigns cnt_d; a missing else would infer a latch.
      cnt_d = cnt_q;
      if (en_i) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // NOTE: state uses <= so all flops sample pre-edge values regardless of block order.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard control: merges load-use, EX redirects and memory readiness
// into per-stage stall/flush controls, with deferred redirects and perf counters.
module hazard_unit
   import hazard_unit_pkg::*;
#(
   parameter int FLUSH_CYCLES = 2,
   parameter int CNT_W        = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             load_use_stall_i,
   input  logic             redirect_i,
   input  logic             imem_ready_i,
   input  logic             dmem_req_i,
   input  logic             dmem_ready_i,
   output logic             pc_stall_o,
   output logic             if_id_stall_o,
   output logic             id_ex_stall_o,
   output logic             ex_mem_stall_o,
   output logic             mem_wb_stall_o,
   output logic             if_id_flush_o,
   output logic             id_ex_flush_o,
   output logic             redirect_take_o,
   output logic [CNT_W-1:0] stall_cnt_o,
   output logic [CNT_W-1:0] flush_cnt_o
);

   localparam logic [FLUSH_CTR_W-1:0] FLUSH_LOAD    = FLUSH_CTR_W'(FLUSH_CYCLES - 1);
   localparam hz_state_t              REDIRECT_NEXT = (FLUSH_CYCLES > 1) ? HZ_FLUSH : HZ_RUN;

   hz_state_t              state_d, state_q;
   logic [FLUSH_CTR_W-1:0] flush_ctr_d, flush_ctr_q;
   logic                   pend_redirect_d, pend_redirect_q;

   logic       mem_freeze;
   pipe_ctrl_t ctrl;
   pipe_ctrl_t ctrl_out;

   assign mem_freeze = dmem_req_i && !dmem_ready_i;

   always_comb begin
      state_d         = state_q;
      flush_ctr_d     = flush_ctr_q;
      pend_redirect_d = pend_redirect_q;
      ctrl            = ctrl_idle();

      unique case (state_q)
         HZ_RUN: begin
            if (mem_freeze) begin
               ctrl = ctrl_freeze();
               if (redirect_i) begin
                  pend_redirect_d = 1'b1;
                  state_d         = HZ_FREEZE_PEND;
               end
            end else if (redirect_i) begin
               // ID holds a wrong-path instruction, so load-use is moot here.
               ctrl        = ctrl_redirect();
               flush_ctr_d = FLUSH_LOAD;
               state_d     = REDIRECT_NEXT;
            end else if (load_use_stall_i) begin
               ctrl = ctrl_load_use();
            end else if (!imem_ready_i) begin
               ctrl = ctrl_imem_miss();
            end
         end

         HZ_FLUSH: begin
            if (mem_freeze) begin
               ctrl = ctrl_freeze();
               if (redirect_i) begin
                  pend_redirect_d = 1'b1;
                  state_d         = HZ_FREEZE_PEND;
               end
            end else if (redirect_i) begin
               ctrl        = ctrl_redirect();
               flush_ctr_d = FLUSH_LOAD;
               state_d     = REDIRECT_NEXT;
            end else begin
               ctrl.if_id.flush = 1'b1;
               if (flush_ctr_q <= FLUSH_CTR_W'(1)) begin
                  flush_ctr_d = '0;
                  state_d     = HZ_RUN;
               end else begin
                  flush_ctr_d = flush_ctr_q - FLUSH_CTR_W'(1);
               end
            end
         end

         HZ_FREEZE_PEND: begin
            // EX is held here, so redirect_i is stale and deliberately not sampled.
            if (mem_freeze) begin
               ctrl = ctrl_freeze();
            end else begin
               pend_redirect_d = 1'b0;
               if (pend_redirect_q) begin
                  ctrl        = ctrl_redirect();
                  flush_ctr_d = FLUSH_LOAD;
                  state_d     = REDIRECT_NEXT;
               end else begin
                  state_d = HZ_RUN;
               end
            end
         end

         default: begin
            state_d         = HZ_RUN;
            flush_ctr_d     = '0;
            pend_redirect_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q         <= HZ_RUN;
         flush_ctr_q     <= '0;
         pend_redirect_q <= 1'b0;
      end else begin
         state_q         <= state_d;
         flush_ctr_q     <= flush_ctr_d;
         pend_redirect_q <= pend_redirect_d;
      end
   end

   // Outputs are combinational, so they are forced quiet for the whole reset window.
   assign ctrl_out = rst_i ? ctrl_idle() : ctrl;

   assign pc_stall_o      = ctrl_out.pc_stall;
   assign if_id_stall_o   = ctrl_out.if_id.stall;
   assign id_ex_stall_o   = ctrl_out.id_ex.stall;
   assign ex_mem_stall_o  = ctrl_out.ex_mem_stall;
   assign mem_wb_stall_o  = ctrl_out.mem_wb_stall;
   assign if_id_flush_o   = ctrl_out.if_id.flush;
   assign id_ex_flush_o   = ctrl_out.id_ex.flush;
   assign redirect_take_o = ctrl_out.redirect_take;

   perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .en_i  (ctrl_out.pc_stall),
      .cnt_o (stall_cnt_o)
   );

   perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .en_i  (ctrl_out.id_ex.flush),
      .cnt_o (flush_cnt_o)
   );

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Central pipeline-control block for the 5-stage core. It sits directly downstream of the decode/execute forwarding logic and consumes its load-use stall indication.
- Combines that indication with branch/jump redirects from EX and instruction/data memory readiness. From these it drives per-stage stall (hold) and flush (bubble) controls.
- Holds the sequential state the combinational forwarder cannot:
  - multi-cycle redirect flushes covering fetches already in flight;
  - redirects captured during a memory freeze and deferred until it releases;
  - free-running stall/flush performance counters.

Parameters:
- FLUSH_CYCLES, 2, number of consecutive cycles IF/ID is flushed after a redirect (covers synchronous imem latency); legal range 1..7.
- CNT_W, 32, width of each performance counter.

Ports:
- clk_i  in  1  core clock; all state updates on rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- load_use_stall_i  in  1  load-use hazard from forward unit (instruction in ID needs a load result currently in EX).
- redirect_i  in  1  EX stage taken branch / jump / trap redirect, valid this cycle.
- imem_ready_i  in  1  instruction memory delivers a valid instruction this cycle.
- dmem_req_i  in  1  MEM stage holds a load/store this cycle.
- dmem_ready_i  in  1  data memory completes the MEM-stage access this cycle.
- pc_stall_o  out  1  hold PC.
- if_id_stall_o  out  1  hold IF/ID register.
- id_ex_stall_o  out  1  hold ID/EX register.
- ex_mem_stall_o  out  1  hold EX/MEM register.
- mem_wb_stall_o  out  1  hold MEM/WB register.
- if_id_flush_o  out  1  load a bubble into IF/ID.
- id_ex_flush_o  out  1  load a bubble into ID/EX.
- redirect_take_o  out  1  PC must load the EX redirect target this cycle.
- stall_cnt_o  out  CNT_W  cycles in which pc_stall_o was high.
- flush_cnt_o  out  CNT_W  cycles in which id_ex_flush_o was high.

Behaviour:
- Freeze condition: mem_freeze = dmem_req_i && !dmem_ready_i.
- State machine, states RUN, FLUSH, FREEZE_PEND.
- RUN, in priority order:
  - mem_freeze: all five stall outputs 1, no flushes, redirect_take_o 0. If redirect_i is high, set pend_redirect and go to FREEZE_PEND.
  - redirect_i: redirect_take_o 1, if_id_flush_o 1, id_ex_flush_o 1, stalls 0.
    - Load redirect counter flush_ctr = FLUSH_CYCLES-1. If that is non-zero go to FLUSH, else stay in RUN.
    - load_use_stall_i is ignored because ID holds a wrong-path instruction.
  - load_use_stall_i: pc_stall_o, if_id_stall_o and id_ex_flush_o are 1; EX/MEM/WB stages advance.
  - !imem_ready_i: pc_stall_o 1 and if_id_flush_o 1; downstream stages advance.
  - else: all outputs 0.
- FLUSH:
  - if_id_flush_o 1 each cycle; decrement flush_ctr; return to RUN when it reaches 0.
  - mem_freeze freezes everything and also freezes flush_ctr.
  - A new redirect_i reloads the counter and asserts redirect_take_o, if_id_flush_o and id_ex_flush_o.
  - load_use_stall_i is ignored.
- FREEZE_PEND:
  - All stalls 1 while mem_freeze holds.
  - The redirect is not re-sampled; EX is held, so redirect_i stays asserted and is don't-care.
  - On the first cycle without freeze: redirect_take_o 1, both flushes 1, clear pend_redirect, load flush_ctr, then go to FLUSH (or RUN if FLUSH_CYCLES=1).
- Simultaneous events:
  - A stall output and a flush output for the same register are never both 1; the flush wins only where stall is 0 by the rules above.
  - mem_freeze and redirect in the same cycle: the freeze wins and the redirect is deferred.
- Counters:
  - Increment by 1 in any cycle where the respective output is 1.
  - Wrap modulo 2^CNT_W and never saturate.
  - Reset to 0.
- Reset (asynchronous, rst_i=1):
  - state=RUN, flush_ctr=0, pend_redirect=0, counters 0.
  - All outputs 0 while in reset.
  - Reset asserted mid-FLUSH or mid-FREEZE_PEND discards the pending redirect.
- All outputs are combinational from state plus inputs (zero-cycle latency). Only state, flush_ctr, pend_redirect and the counters are registered.

Decomposition:
- Shared pipeline package (alongside the existing pipeline-register typedefs) gets:
  - enum hz_state_t {HZ_RUN, HZ_FLUSH, HZ_FREEZE_PEND};
  - struct stage_ctrl_t {stall, flush}, used per pipeline register.
- One natural sub-module: perf_counter (CNT_W-bit enable-driven wrapping counter, async active-high reset), instantiated twice.

Test Plan:
- Load-use: load_use_stall_i=1 for 1 cycle, memories ready -> that cycle pc_stall_o=1, if_id_stall_o=1, id_ex_flush_o=1, others 0; next cycle all 0; stall_cnt_o=1, flush_cnt_o=1.
- Redirect, FLUSH_CYCLES=2: redirect_i pulse -> cycle0 redirect_take_o=1, both flushes=1; cycle1 if_id_flush_o=1 only; cycle2 all 0; flush_cnt_o=1.
- Freeze with redirect: dmem_req_i=1, dmem_ready_i=0 for 3 cycles with redirect_i=1 -> 3 cycles all stalls=1, redirect_take_o=0. Then dmem_ready_i=1 -> redirect_take_o=1 and both flushes that cycle; if_id_flush_o the next cycle; stall_cnt_o=3.
- Priority: redirect_i=1 and load_use_stall_i=1 together -> pc_stall_o=0, redirect_take_o=1, id_ex_flush_o=1, if_id_stall_o=0.
- Imem miss: imem_ready_i=0 for 2 cycles -> pc_stall_o=1 and if_id_flush_o=1 both cycles, id_ex_stall_o=0.
- Reset mid-FREEZE_PEND: rst_i asserted asynchronously (between clock edges) -> outputs 0 immediately, counters 0. After release with freeze gone, redirect_take_o stays 0.
